// File: rtl/sha256_pkg.sv
// Constants and types shared by the SHA-256 padder and compression core.
// put_byte writes one big-endian byte lane of a block (byte 0 is the MSB).
package sha256_pkg;

   localparam int BLOCK_W = 512;
   localparam int BLK_BYTES = 64;
   localparam int LEN_POS = 56;
   localparam logic [7:0] PAD_BYTE = 8'h80;

   typedef enum logic [1:0] {
      FILL,
      PAD,
      EMIT,
      TAIL
   } pad_state_t;

   function automatic logic [BLOCK_W-1:0] put_byte(input logic [BLOCK_W-1:0] blk,
                                                   input logic [5:0] pos,
                                                   input logic [7:0] val);
      logic [BLOCK_W-1:0] res;
      res = blk;
      for (int k = 0; k < BLK_BYTES; k++) begin
         if (pos == 6'(k)) begin
            res[BLOCK_W-1-8*k -: 8] = val;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/sha256_padder.sv
// Byte-stream to padded 512-bit block converter for the SHA-256 core.
// Emits data, 0x80, zero fill and the 64-bit bit length, one block per handshake.
module sha256_padder
   import sha256_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [7:0]         in_data,
   input  logic               in_last,
   output logic               blk_valid,
   input  logic               blk_ready,
   output logic [BLOCK_W-1:0] blk_data,
   output logic               blk_first,
   output logic               blk_last
);

   pad_state_t         state_reg, state_next;
   logic [BLOCK_W-1:0] blk_reg, blk_next;
   logic [5:0]         idx_reg, idx_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic               mark_reg, mark_next;
   logic               tail_reg, tail_next;
   logic               first_reg, first_next;
   logic               last_reg, last_next;
   logic [63:0]        len_field;

   // Bit length is the byte count shifted by three, zero-extended to 64 bits.
   assign len_field = 64'({cnt_reg, 3'b000});

   assign in_ready  = !rst && (state_reg == FILL);
   assign blk_valid = !rst && (state_reg == EMIT);
   assign blk_first = blk_valid && first_reg;
   assign blk_last  = blk_valid && last_reg;
   assign blk_data  = blk_reg;

   always_comb begin
      state_next = state_reg;
      blk_next   = blk_reg;
      idx_next   = idx_reg;
      cnt_next   = cnt_reg;
      mark_next  = mark_reg;
      tail_next  = tail_reg;
      first_next = first_reg;
      last_next  = last_reg;
      case (state_reg)
         FILL: begin
            if (in_valid) begin
               blk_next = put_byte(blk_reg, idx_reg, in_data);
               idx_next = idx_reg + 6'd1;
               cnt_next = cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
               if (in_last && idx_reg == 6'd63) begin
                  // Block is full of data: marker and length both go in a tail block.
                  state_next = EMIT;
                  mark_next  = 1'b1;
                  tail_next  = 1'b1;
                  last_next  = 1'b0;
               end else if (in_last) begin
                  state_next = PAD;
               end else if (idx_reg == 6'd63) begin
                  state_next = EMIT;
                  last_next  = 1'b0;
               end
            end
         end
         PAD: begin
            blk_next = put_byte(blk_reg, idx_reg, PAD_BYTE);
            if (idx_reg <= 6'(LEN_POS - 1)) begin
               blk_next[63:0] = len_field;
               last_next      = 1'b1;
            end else begin
               tail_next = 1'b1;
               last_next = 1'b0;
            end
            state_next = EMIT;
         end
         EMIT: begin
            if (blk_ready) begin
               blk_next   = '0;
               idx_next   = 6'd0;
               first_next = 1'b0;
               if (last_reg) begin
                  cnt_next   = '0;
                  first_next = 1'b1;
               end
               state_next = tail_reg ? TAIL : FILL;
            end
         end
         TAIL: begin
            if (mark_reg) begin
               blk_next[BLOCK_W-1 -: 8] = PAD_BYTE;
            end
            blk_next[63:0] = len_field;
            mark_next      = 1'b0;
            tail_next      = 1'b0;
            last_next      = 1'b1;
            state_next     = EMIT;
         end
         default: state_next = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= FILL;
         blk_reg   <= '0;
         idx_reg   <= 6'd0;
         cnt_reg   <= '0;
         mark_reg  <= 1'b0;
         tail_reg  <= 1'b0;
         first_reg <= 1'b1;
         last_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         blk_reg   <= blk_next;
         idx_reg   <= idx_next;
         cnt_reg   <= cnt_next;
         mark_reg  <= mark_next;
         tail_reg  <= tail_next;
         first_reg <= first_next;
         last_reg  <= last_next;
      end
   end

endmodule
